demux1to2_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer; the counterpart of the team's 2-to-1 mux blocks.
- Routes one valid/ready input stream to one of two output streams (out0/out1), selected per beat by in_sel.
- Each output has a one-entry holding register, so an output stall never corrupts the data already held.
- Used wherever one producer feeds two consumers.

---
 rtl/demux1to2_stream.sv | 135 +++++++++++++
 tb/tb_demux1to2_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with a one-entry holding slot per output.
// Optional per-output delivered-beat counters are built when DEMUX_CNT_EN is defined.
module demux1to2_stream #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out0_data,
  output logic          out0_valid,
  input  logic          out0_ready,
  output logic [DW-1:0] out1_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e   slot0_q, slot0_d;
  slot_state_e   slot1_q, slot1_d;
  logic [DW-1:0] data0_q, data0_d;
  logic [DW-1:0] data1_q, data1_d;
  logic          acc0, acc1;

  // Slot state and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= SLOT_EMPTY;
      slot1_q <= SLOT_EMPTY;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  // Ready follows the addressed slot only, so a stalled slot never blocks the other
  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    in_ready = 1'b1;
    acc0     = 1'b0;
    acc1     = 1'b0;

    if (in_sel) begin
      in_ready = (slot1_q == SLOT_EMPTY) | out1_ready;
    end else begin
      in_ready = (slot0_q == SLOT_EMPTY) | out0_ready;
    end

    acc0 = in_valid & in_ready & ~in_sel;
    acc1 = in_valid & in_ready & in_sel;

    case (slot0_q)
      SLOT_EMPTY: begin
        if (acc0) begin
          slot0_d = SLOT_FULL;
          data0_d = in_data;
        end
      end
      SLOT_FULL: begin
        if (acc0) begin
          data0_d = in_data;
        end else if (out0_ready) begin
          slot0_d = SLOT_EMPTY;
        end
      end
    endcase

    case (slot1_q)
      SLOT_EMPTY: begin
        if (acc1) begin
          slot1_d = SLOT_FULL;
          data1_d = in_data;
        end
      end
      SLOT_FULL: begin
        if (acc1) begin
          data1_d = in_data;
        end else if (out1_ready) begin
          slot1_d = SLOT_EMPTY;
        end
      end
    endcase
  end

  assign out0_valid = (slot0_q == SLOT_FULL);
  assign out1_valid = (slot1_q == SLOT_FULL);
  assign out0_data  = data0_q;
  assign out1_data  = data1_q;

`ifdef DEMUX_CNT_EN
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;

  // Delivered-beat counters wrap silently
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (out0_valid & out0_ready) cnt0_d = cnt0_q + CW'(1);
    if (out1_valid & out1_ready) cnt1_d = cnt1_q + CW'(1);
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
// Self-checking bench for demux1to2_stream: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a per-slot behavioural model.
module tb_demux1to2_stream;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
`ifdef DEMUX_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [DW-1:0] out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  demux1to2_stream #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: each output holds at most one beat; counts are delivered beats mod 2^CW
  bit        m_full[2];
  logic [7:0] m_data[2];
  int        m_cnt[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit out_rdy(input int s);
    return (s == 0) ? out0_ready : out1_ready;
  endfunction

  function automatic bit model_in_ready();
    int s;
    s = in_sel ? 1 : 0;
    return !m_full[s] || out_rdy(s);
  endfunction

  // One clock: check comb ready, advance model on the edge, then compare registered outputs
  task automatic cycle();
    bit acc;
    int s;
    #1 chk("in_ready", 32'(in_ready), 32'(model_in_ready()));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_full[i] = 1'b0;
        m_data[i] = 8'h00;
        m_cnt[i]  = 0;
      end
    end else begin
      acc = in_valid && model_in_ready();
      s   = in_sel ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
        if (m_full[i] && out_rdy(i)) begin
          m_full[i] = 1'b0;
          m_cnt[i]  = (m_cnt[i] + 1) % (1 << CW);
        end
      end
      if (acc) begin
        m_full[s] = 1'b1;
        m_data[s] = in_data;
      end
    end
    @(negedge clk);
    chk("out0_valid", 32'(out0_valid), 32'(m_full[0]));
    chk("out1_valid", 32'(out1_valid), 32'(m_full[1]));
    if (m_full[0]) chk("out0_data", 32'(out0_data), 32'(m_data[0]));
    if (m_full[1]) chk("out1_data", 32'(out1_data), 32'(m_data[1]));
    chk("cnt0", 32'(cnt0), CNT_ON ? 32'(m_cnt[0]) : 32'd0);
    chk("cnt1", 32'(cnt1), CNT_ON ? 32'(m_cnt[1]) : 32'd0);
  endtask

  task automatic drive(input bit v, input bit sel, input logic [7:0] d);
    in_valid = v;
    in_sel   = sel;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0; m_data[i] = 8'h00; m_cnt[i] = 0;
    end
    @(negedge clk);

    // Reset then idle
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data", 32'(out0_data), 32'd0);
    chk("rst_out1_data", 32'(out1_data), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single routing
    drive(1'b1, 1'b0, 8'hA5);
    cycle();
    chk("route_out0_valid", 32'(out0_valid), 32'd1);
    chk("route_out0_data", 32'(out0_data), 32'hA5);
    chk("route_out1_valid", 32'(out1_valid), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    cycle();
    chk("route_out0_once", 32'(out0_valid), 32'd0);
    chk("route_cnt0", 32'(cnt0), CNT_ON ? 32'd1 : 32'd0);

    // Backpressure on out1 while out0 keeps flowing
    out1_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h3C);
    cycle();
    chk("bp_out1_data", 32'(out1_data), 32'h3C);
    drive(1'b1, 1'b1, 8'h77);
    #1 chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    cycle();
    chk("bp_out1_held", 32'(out1_data), 32'h3C);
    drive(1'b1, 1'b0, 8'h11);
    #1 chk("bp_in_ready_sel0", 32'(in_ready), 32'd1);
    cycle();
    chk("bp_out0_data", 32'(out0_data), 32'h11);
    chk("bp_out1_still", 32'(out1_data), 32'h3C);
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h77);
    cycle();
    chk("bp_out1_next", 32'(out1_data), 32'h77);
    chk("bp_out1_valid", 32'(out1_valid), 32'd1);
    drive(1'b0, 1'b0, 8'h00);
    cycle();

    // Simultaneous drain and load on out0
    drive(1'b1, 1'b0, 8'h01);
    cycle();
    drive(1'b1, 1'b0, 8'h02);
    #1 chk("dl_in_ready", 32'(in_ready), 32'd1);
    cycle();
    chk("dl_out0_valid", 32'(out0_valid), 32'd1);
    chk("dl_out0_data", 32'(out0_data), 32'h02);
    drive(1'b0, 1'b0, 8'h00);
    cycle();

    // Mid-operation reset with both slots full
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive(1'b1, 1'b0, 8'hAA); cycle();
    drive(1'b1, 1'b1, 8'hBB); cycle();
    drive(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mrst_out0_valid", 32'(out0_valid), 32'd0);
    chk("mrst_out1_valid", 32'(out1_valid), 32'd0);
    chk("mrst_cnt0", 32'(cnt0), 32'd0);
    chk("mrst_cnt1", 32'(cnt1), 32'd0);
    out0_ready = 1'b1; out1_ready = 1'b1;
    drive(1'b1, 1'b1, 8'hF0);
    cycle();
    chk("mrst_out1_data", 32'(out1_data), 32'hF0);
    chk("mrst_out0_idle", 32'(out0_valid), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    cycle();

    // Counter wrap: 256 beats delivered on out0 from a clean reset
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      cycle();
    end
    chk("wrap_cnt0_255", 32'(cnt0), CNT_ON ? 32'd255 : 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    cycle();
    chk("wrap_cnt0_0", 32'(cnt0), 32'd0);
    chk("wrap_out0_empty", 32'(out0_valid), 32'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom_range(0, 1));
      in_data    = 8'($urandom);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
